// File: rtl/running_mean_acc.sv
// running_mean_acc
//   Sliding-window sum and mean over the last WIN = 2**LOG2_WIN signed samples.
//   Samples arrive on a valid/ready stream; one result is buffered on the output
//   stream and is registered on the edge that accepts the sample.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst      : asynchronous active-high reset
//   clear    : synchronous flush of window, sum and output stage
//   s_valid  : input sample valid
//   s_ready  : block can accept a sample this cycle
//   s_data   : input sample, signed DATA_W bits
//   m_valid  : result valid
//   m_ready  : downstream accepts the result
//   m_sum    : window sum, signed DATA_W+LOG2_WIN bits
//   m_mean   : window sum >>> LOG2_WIN (floor), signed DATA_W bits
//   m_full   : result was computed over a completely filled window
module running_mean_acc #(
    parameter int DATA_W   = 32,
    parameter int LOG2_WIN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_W-1:0]          s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W+LOG2_WIN-1:0] m_sum,
    output logic [DATA_W-1:0]          m_mean,
    output logic                       m_full
);

    localparam int WIN   = 1 << LOG2_WIN;
    localparam int SUM_W = DATA_W + LOG2_WIN;
    localparam int CNT_W = LOG2_WIN + 1;
    localparam int PTR_W = LOG2_WIN;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_count;
    logic [PTR_W-1:0]          r_wptr;
    logic signed [SUM_W-1:0]   r_sum;
    logic                      r_m_valid;
    logic [SUM_W-1:0]          r_m_sum;
    logic [DATA_W-1:0]         r_m_mean;
    logic                      r_m_full;

    // Sample ring; contents are never reset, only gated by the FILL state.
    logic [DATA_W-1:0]         r_buf [WIN];

    logic                      w_accept;
    logic [DATA_W-1:0]         w_oldest;
    logic signed [SUM_W-1:0]   w_new_ext;
    logic signed [SUM_W-1:0]   w_old_ext;
    logic signed [SUM_W-1:0]   w_sum_next;
    logic signed [SUM_W-1:0]   w_mean_wide;
    logic                      w_full_next;

    assign s_ready  = (!r_m_valid || m_ready) && !clear;
    assign w_accept = s_valid && s_ready;

    // While filling, slots not yet written this window hold stale data;
    // treat the evicted value as zero so missing entries count as zero.
    assign w_oldest    = (r_state == RUN) ? r_buf[r_wptr] : '0;
    assign w_new_ext   = {{LOG2_WIN{s_data[DATA_W-1]}}, s_data};
    assign w_old_ext   = {{LOG2_WIN{w_oldest[DATA_W-1]}}, w_oldest};
    assign w_sum_next  = r_sum + w_new_ext - w_old_ext;
    assign w_mean_wide = w_sum_next >>> LOG2_WIN;
    // This accept completes the window if we are already full or it is the WIN-th.
    assign w_full_next = (r_state == RUN) || (r_count == CNT_W'(WIN - 1));

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_wptr] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= FILL;
            r_count   <= '0;
            r_wptr    <= '0;
            r_sum     <= '0;
            r_m_valid <= 1'b0;
            r_m_sum   <= '0;
            r_m_mean  <= '0;
            r_m_full  <= 1'b0;
        end else if (clear) begin
            r_state   <= FILL;
            r_count   <= '0;
            r_wptr    <= '0;
            r_sum     <= '0;
            r_m_valid <= 1'b0;
            r_m_full  <= 1'b0;
        end else if (w_accept) begin
            r_sum     <= w_sum_next;
            r_wptr    <= r_wptr + PTR_W'(1);
            r_m_valid <= 1'b1;
            r_m_sum   <= w_sum_next;
            r_m_mean  <= w_mean_wide[DATA_W-1:0];
            r_m_full  <= w_full_next;
            case (r_state)
                FILL: begin
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == CNT_W'(WIN - 1)) begin
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end else if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_valid = r_m_valid;
    assign m_sum   = r_m_sum;
    assign m_mean  = r_m_mean;
    assign m_full  = r_m_full;

endmodule

// File: tb/tb_running_mean_acc.sv
// tb_running_mean_acc
//   Directed-vector bench for running_mean_acc with WIN = 4, DATA_W = 32.
//   Expected values are hand-computed constants in the stimulus below.
module tb_running_mean_acc;

    localparam int DATA_W   = 32;
    localparam int LOG2_WIN = 2;
    localparam int SUM_W    = DATA_W + LOG2_WIN;

    logic              clk;
    logic              rst;
    logic              clear;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [SUM_W-1:0]  m_sum;
    logic [DATA_W-1:0] m_mean;
    logic              m_full;

    int n_tests = 0;
    int n_fail  = 0;

    running_mean_acc #(
        .DATA_W   (DATA_W),
        .LOG2_WIN (LOG2_WIN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_sum   (m_sum),
        .m_mean  (m_mean),
        .m_full  (m_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one sample for one cycle; results are read 1 time unit after the edge.
    task automatic send(input string tag, input logic signed [DATA_W-1:0] d);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        #1;
        check({tag, ".s_ready"}, longint'(s_ready), 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input longint sum, input longint mean,
                                 input longint full);
        check({tag, ".m_valid"}, longint'(m_valid), 1);
        check({tag, ".m_sum"},   longint'($signed(m_sum)), sum);
        check({tag, ".m_mean"},  longint'($signed(m_mean)), mean);
        check({tag, ".m_full"},  longint'(m_full), full);
    endtask

    int fill_in   [5] = '{4, 8, 12, 16, 20};
    int fill_sum  [5] = '{4, 12, 24, 40, 56};
    int fill_mean [5] = '{1, 3, 6, 10, 14};
    int fill_full [5] = '{0, 0, 0, 1, 1};

    initial begin
        rst     = 1'b1;
        clear   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        #1;
        check("rst.m_valid", longint'(m_valid), 0);
        check("rst.m_sum",   longint'(m_sum), 0);
        check("rst.m_mean",  longint'(m_mean), 0);
        check("rst.m_full",  longint'(m_full), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst.s_ready", longint'(s_ready), 1);

        // Fill then slide
        for (int i = 0; i < 5; i++) begin
            send($sformatf("fill%0d", i), fill_in[i]);
            expect_result($sformatf("fill%0d", i), fill_sum[i], fill_mean[i], fill_full[i]);
        end

        // Negative floor
        do_reset();
        send("neg", -5);
        expect_result("neg", -5, -2, 0);

        // Backpressure
        do_reset();
        send("bp0", 3);
        expect_result("bp0", 3, 0, 0);
        @(negedge clk);
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 10;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_hold%0d.s_ready", i), longint'(s_ready), 0);
            @(posedge clk);
            #1;
            check($sformatf("bp_hold%0d.m_valid", i), longint'(m_valid), 1);
            check($sformatf("bp_hold%0d.m_sum", i), longint'($signed(m_sum)), 3);
            @(negedge clk);
        end
        m_ready = 1'b1;
        #1;
        check("bp_drain.s_ready", longint'(s_ready), 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        expect_result("bp_drain", 13, 3, 0);
        @(posedge clk);
        #1;
        check("bp_idle.m_valid", longint'(m_valid), 0);

        // Wrap-around
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            send($sformatf("wrap%0d", i), i);
        end
        expect_result("wrap", 30, 7, 1);
        check("wrap.wptr", longint'(dut.r_wptr), 1);

        // Clear mid-stream
        do_reset();
        send("clr1", 1);
        send("clr2", 2);
        send("clr3", 3);
        expect_result("clr3", 6, 1, 0);
        @(negedge clk);
        clear   = 1'b1;
        s_valid = 1'b1;
        s_data  = 100;
        #1;
        check("clr.s_ready", longint'(s_ready), 0);
        @(posedge clk);
        #1;
        clear   = 1'b0;
        s_valid = 1'b0;
        check("clr.m_valid", longint'(m_valid), 0);
        check("clr.m_full",  longint'(m_full), 0);
        send("clr_after", 8);
        expect_result("clr_after", 8, 2, 0);

        // Asynchronous reset mid-stream, sampled before the next edge
        send("arst1", 20);
        expect_result("arst1", 28, 7, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst.m_valid", longint'(m_valid), 0);
        check("arst.m_sum",   longint'(m_sum), 0);
        check("arst.m_mean",  longint'(m_mean), 0);
        check("arst.m_full",  longint'(m_full), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
